rf_dump_uart: RTL

Debug-bus initiator that sweeps the CPU register file and streams every register out over a UART transmit line. It drives the register-read address (`rf_ra`), samples the returned value (`rf_rd`), and serializes each 32-bit word as four 8N1 bytes. It sits in the FPGA top level beside the display controller and gives a host PC a full register snapshot on a single trigger.

---
 rtl/global_types.sv | 19 +
 rtl/rf_dump_uart_if.sv | 11 +
 rtl/uart_tx.sv | 75 +++++++
 rtl/rf_dump_uart.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/global_types.sv
// Shared types and constants for the register-file dump path.
package global_types;

    typedef logic [31:0] logic32;

    typedef enum logic [2:0] {
        StIdle,
        StSetAddr,
        StCapture,
        StLoadByte,
        StWaitTx,
        StNext,
        StHdrSync,
        StHdrPc
    } rf_dump_state_t;

    localparam logic [7:0] RF_DUMP_SYNC = 8'hA5;

endpackage

// File: rtl/rf_dump_uart_if.sv
// Register-file read bus: the dumper drives the address, the register file returns data.
interface rf_dump_uart_if;
    import global_types::*;

    logic [4:0] rf_ra;
    logic32     rf_rd;

    modport master (output rf_ra, input rf_rd);
    modport slave  (input rf_ra, output rf_rd);

endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte handshake; each bit lasts CLKS_PER_BIT cycles.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int unsigned     BaudW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    logic             active_q, active_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [3:0]       bit_q, bit_d;
    logic [8:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             last_tick;
    logic             accept;

    // Ready already during the final stop-bit cycle so a new frame can follow with no gap.
    assign last_tick = active_q && (baud_q == BaudLast) && (bit_q == 4'd9);
    assign ready     = !active_q || last_tick;
    assign accept    = valid && ready;
    assign tx        = tx_q;

    always_comb begin
        active_d = active_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        if (accept) begin
            active_d = 1'b1;
            baud_d   = '0;
            bit_d    = 4'd0;
            shift_d  = {1'b1, data};
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (baud_q == BaudLast) begin
                baud_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                end
            end else begin
                baud_d = baud_q + BaudW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/rf_dump_uart.sv
// Sweeps the register file and streams each word MSB byte first over UART.
// Define RF_DUMP_HEADER_EN to prefix the dump with 0xA5 and the PC captured at start.
module rf_dump_uart
    import global_types::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned NUM_REGS     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic32            pc,
    rf_dump_uart_if.master    rf,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0] LastIdx = 5'(NUM_REGS - 1);

    rf_dump_state_t state_q, state_d;
    logic [4:0]     idx_q, idx_d;
    logic32         word_q, word_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           tx_valid;
    logic           tx_ready;
    logic [7:0]     tx_data;
    logic [7:0]     cur_byte;

`ifndef RF_DUMP_HEADER_EN
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

    assign cur_byte = word_q[{cnt_q, 3'b000} +: 8];
    assign tx_valid = (state_q == StLoadByte) || (state_q == StHdrSync) || (state_q == StHdrPc);
    assign tx_data  = (state_q == StHdrSync) ? RF_DUMP_SYNC : cur_byte;

    assign rf.rf_ra = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d = 1'b1;
                    idx_d  = 5'd0;
`ifdef RF_DUMP_HEADER_EN
                    word_d  = pc;
                    state_d = StHdrSync;
`else
                    state_d = StSetAddr;
`endif
                end
            end
            StHdrSync: begin
                if (tx_ready) begin
                    cnt_d   = 2'd3;
                    state_d = StHdrPc;
                end
            end
            StHdrPc: begin
                if (tx_ready) begin
                    if (cnt_q != 2'd0) begin
                        cnt_d = cnt_q - 2'd1;
                    end else begin
                        state_d = StSetAddr;
                    end
                end
            end
            StSetAddr: state_d = StCapture;
            StCapture: begin
                word_d  = rf.rf_rd;
                cnt_d   = 2'd3;
                state_d = StLoadByte;
            end
            StLoadByte: begin
                if (tx_ready) begin
                    state_d = StWaitTx;
                end
            end
            StWaitTx: begin
                // After a word's last byte, fetch the next word while the frame is still on the
                // line; only the final register must wait for its stop bit before finishing.
                if (cnt_q != 2'd0) begin
                    if (tx_ready) begin
                        cnt_d   = cnt_q - 2'd1;
                        state_d = StLoadByte;
                    end
                end else if ((idx_q != LastIdx) || tx_ready) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = StSetAddr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= 5'd0;
            word_q  <= '0;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clock(clock),
        .reset(reset),
        .data (tx_data),
        .valid(tx_valid),
        .ready(tx_ready),
        .tx   (tx)
    );

endmodule
